// File: rtl/dpram_ext.sv
// True dual-port byte-enabled RAM with read-first ports, configurable read latency
// and an optional post-reset fill sequence.
module dpram_ext #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ram_cs,
    input  logic                ram_we,
    input  logic [DATA_W/8-1:0] ram_be,
    input  logic [ADDR_W-1:0]   ram_ad,
    input  logic [DATA_W-1:0]   ram_d,
    output logic [DATA_W-1:0]   ram_q,
    output logic                ram_ack,
    input  logic                ram_cs_b,
    input  logic                ram_we_b,
    input  logic [DATA_W/8-1:0] ram_be_b,
    input  logic [ADDR_W-1:0]   ram_ad_b,
    input  logic [DATA_W-1:0]   ram_d_b,
    output logic [DATA_W-1:0]   ram_q_b,
    output logic                ram_ack_b,
    output logic                busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic   BUSY_RST  = (CLEAR_ON_RESET != 0);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    logic              acc_a;
    logic              acc_b;
    logic              wr_a;
    logic              wr_b;
    logic [DATA_W-1:0] s1_q_a;
    logic [DATA_W-1:0] s1_q_b;
    logic              s1_v_a;
    logic              s1_v_b;

    assign acc_a = ram_cs   & ~busy;
    assign acc_b = ram_cs_b & ~busy;
    assign wr_a  = acc_a & ram_we;
    assign wr_b  = acc_b & ram_we_b;

    // Clear FSM state, fill counter and busy flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
            busy    <= BUSY_RST;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == CLEAR);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: begin
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = READY;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    // Array writes; port A is applied last so it owns bytes both ports enable
    always_ff @(posedge clk_sys) begin
        if (busy) begin
            mem[clr_cnt] <= CLEAR_VAL;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b && ram_be_b[i]) begin
                    mem[ram_ad_b][8*i +: 8] <= ram_d_b[8*i +: 8];
                end
                if (wr_a && ram_be[i]) begin
                    mem[ram_ad][8*i +: 8] <= ram_d[8*i +: 8];
                end
            end
        end
    end

    // First read stage samples the pre-write word for reads and writes alike
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_q_a <= '0;
            s1_q_b <= '0;
            s1_v_a <= 1'b0;
            s1_v_b <= 1'b0;
        end else begin
            s1_v_a <= acc_a;
            s1_v_b <= acc_b;
            if (acc_a) begin
                s1_q_a <= mem[ram_ad];
            end
            if (acc_b) begin
                s1_q_b <= mem[ram_ad_b];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_q_a;
        logic [DATA_W-1:0] s2_q_b;
        logic              s2_v_a;
        logic              s2_v_b;

        // Extra output register, advanced only when a word completes
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                s2_q_a <= '0;
                s2_q_b <= '0;
                s2_v_a <= 1'b0;
                s2_v_b <= 1'b0;
            end else begin
                s2_v_a <= s1_v_a;
                s2_v_b <= s1_v_b;
                if (s1_v_a) begin
                    s2_q_a <= s1_q_a;
                end
                if (s1_v_b) begin
                    s2_q_b <= s1_q_b;
                end
            end
        end

        assign ram_q     = s2_q_a;
        assign ram_q_b   = s2_q_b;
        assign ram_ack   = s2_v_a;
        assign ram_ack_b = s2_v_b;
    end else begin : g_lat1
        assign ram_q     = s1_q_a;
        assign ram_q_b   = s1_q_b;
        assign ram_ack   = s1_v_a;
        assign ram_ack_b = s1_v_b;
    end

endmodule

// File: tb/tb_dpram_ext.sv
// Bench for dpram_ext: one RD_LAT=1 and one RD_LAT=2 instance share stimulus
// and are checked against a word-level memory model.
module tb_dpram_ext;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ram_cs, ram_cs_b, ram_we, ram_we_b;
    logic [1:0]  ram_be, ram_be_b;
    logic [3:0]  ram_ad, ram_ad_b;
    logic [15:0] ram_d, ram_d_b;
    logic [15:0] q1_a, q1_b, q2_a, q2_b;
    logic        ack1_a, ack1_b, ack2_a, ack2_b, busy1, busy2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mem_m [DEPTH];
    int          busy_left;
    logic        e_busy;
    logic [15:0] e1_q [2];
    logic [15:0] e2_q [2];
    logic [15:0] pend_q [2];
    logic        e1_ack [2];
    logic        e2_ack [2];
    logic        pend_v [2];

    always #5 clk_sys = ~clk_sys;

    dpram_ext #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_ad(ram_ad), .ram_d(ram_d),
        .ram_q(q1_a), .ram_ack(ack1_a),
        .ram_cs_b(ram_cs_b), .ram_we_b(ram_we_b), .ram_be_b(ram_be_b), .ram_ad_b(ram_ad_b),
        .ram_d_b(ram_d_b), .ram_q_b(q1_b), .ram_ack_b(ack1_b), .busy(busy1));

    dpram_ext #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_ad(ram_ad), .ram_d(ram_d),
        .ram_q(q2_a), .ram_ack(ack2_a),
        .ram_cs_b(ram_cs_b), .ram_we_b(ram_we_b), .ram_be_b(ram_be_b), .ram_ad_b(ram_ad_b),
        .ram_d_b(ram_d_b), .ram_q_b(q2_b), .ram_ack_b(ack2_b), .busy(busy2));

    task automatic idle();
        ram_cs = 1'b0; ram_cs_b = 1'b0; ram_we = 1'b0; ram_we_b = 1'b0;
        ram_be = 2'b00; ram_be_b = 2'b00; ram_ad = '0; ram_ad_b = '0;
        ram_d = '0; ram_d_b = '0;
    endtask

    // One clock: model reacts to the edge, then returns on the falling edge
    task automatic step();
        logic        acc [2];
        logic [15:0] resp [2];
        @(posedge clk_sys);
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
            busy_left = DEPTH;
            e_busy = 1'b1;
            for (int p = 0; p < 2; p++) begin
                e1_q[p] = '0; e2_q[p] = '0; e1_ack[p] = 1'b0; e2_ack[p] = 1'b0;
                pend_v[p] = 1'b0; pend_q[p] = '0;
            end
        end else begin
            acc[0] = ram_cs   && (busy_left == 0);
            acc[1] = ram_cs_b && (busy_left == 0);
            resp[0] = mem_m[ram_ad];
            resp[1] = mem_m[ram_ad_b];
            for (int i = 0; i < 2; i++) begin
                if (acc[1] && ram_we_b && ram_be_b[i]) mem_m[ram_ad_b][8*i +: 8] = ram_d_b[8*i +: 8];
                if (acc[0] && ram_we && ram_be[i])     mem_m[ram_ad][8*i +: 8]   = ram_d[8*i +: 8];
            end
            for (int p = 0; p < 2; p++) begin
                e2_ack[p] = pend_v[p];
                if (pend_v[p]) e2_q[p] = pend_q[p];
                pend_v[p] = acc[p];
                if (acc[p]) pend_q[p] = resp[p];
                e1_ack[p] = acc[p];
                if (acc[p]) e1_q[p] = resp[p];
            end
            if (busy_left > 0) busy_left--;
            e_busy = (busy_left > 0);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        step();
        step();
        checks++;
        if ({q1_a, q1_b, ack1_a, ack1_b, busy1} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_lat1: q=%h q_b=%h ack=%b ack_b=%b busy=%b, expected 0 0 0 0 1",
                     q1_a, q1_b, ack1_a, ack1_b, busy1);
        end
        checks++;
        if ({q2_a, q2_b, ack2_a, ack2_b, busy2} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_lat2: q=%h q_b=%h ack=%b ack_b=%b busy=%b, expected 0 0 0 0 1",
                     q2_a, q2_b, ack2_a, ack2_b, busy2);
        end
    endtask

    task automatic hold_requests(input int k);
        ram_cs = 1'b1; ram_cs_b = 1'b1; ram_we = 1'b1; ram_we_b = 1'b1;
        ram_be = 2'b11; ram_be_b = 2'b11;
        ram_ad = 4'(k); ram_ad_b = 4'(15 - k);
        ram_d = 16'h0000; ram_d_b = 16'hFFFF;
    endtask

    task automatic test_reset_mid_clear();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hold_requests(k);
            step();
            checks++;
            if ({busy1, busy2, ack1_a, ack1_b, ack2_a, ack2_b} !== 6'b110000) begin
                errors++;
                $display("FAIL busy_first_clear[%0d]: busy=%b%b acks=%b%b%b%b, expected busy=11 acks=0000",
                         k, busy1, busy2, ack1_a, ack1_b, ack2_a, ack2_b);
            end
        end
        reset_n = 1'b0;
        step();
        checks++;
        if ({busy1, busy2, q1_a, q2_a} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%b%b q=%h/%h, expected busy=11 q=0",
                     busy1, busy2, q1_a, q2_a);
        end
    endtask

    task automatic test_clear_busy();
        reset_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            hold_requests(k - 1);
            step();
            checks++;
            if ({busy1, busy2} !== {2{k < DEPTH}} || {ack1_a, ack1_b, ack2_a, ack2_b} !== 4'b0) begin
                errors++;
                $display("FAIL busy_window[%0d]: busy=%b%b acks=%b%b%b%b, expected busy=%0d acks=0000",
                         k, busy1, busy2, ack1_a, ack1_b, ack2_a, ack2_b, k < DEPTH);
            end
        end
        idle();
    endtask

    task automatic test_clear_contents();
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            ram_cs_b = 1'b1; ram_ad_b = 4'(a);
            step();
            checks++;
            if ({ack1_b, q1_b} !== {1'b1, CV} || ack1_a !== 1'b0) begin
                errors++;
                $display("FAIL clear_read[%0d]: ack_b=%b q_b=%h ack=%b, expected ack_b=1 q_b=%h ack=0",
                         a, ack1_b, q1_b, ack1_a, CV);
            end
        end
        idle();
        step();
        checks++;
        if ({ack2_b, q2_b} !== {1'b1, CV} || ack1_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_read_lat2_tail: ack2_b=%b q2_b=%h ack1_b=%b, expected 1 %h 0",
                     ack2_b, q2_b, ack1_b, CV);
        end
    endtask

    task automatic test_byte_write();
        idle();
        ram_cs = 1'b1; ram_we = 1'b1; ram_ad = 4'd3; ram_d = 16'h1234; ram_be = 2'b01;
        step();
        checks++;
        if ({ack1_a, q1_a} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL write_resp_old: ack=%b q=%h, expected ack=1 q=a5a5", ack1_a, q1_a);
        end
        idle();
        ram_cs = 1'b1; ram_ad = 4'd3;
        step();
        checks++;
        if ({ack1_a, q1_a} !== {1'b1, 16'hA534}) begin
            errors++;
            $display("FAIL byte_write_read: ack=%b q=%h, expected ack=1 q=a534", ack1_a, q1_a);
        end
        checks++;
        if ({ack2_a, q2_a} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL write_resp_lat2: ack=%b q=%h, expected ack=1 q=a5a5", ack2_a, q2_a);
        end
        idle();
        ram_cs = 1'b1; ram_we = 1'b1; ram_be = 2'b00; ram_ad = 4'd3; ram_d = 16'hFFFF;
        step();
        idle();
        ram_cs = 1'b1; ram_ad = 4'd3;
        step();
        checks++;
        if ({ack1_a, q1_a} !== {1'b1, 16'hA534}) begin
            errors++;
            $display("FAIL be0_noop: ack=%b q=%h, expected ack=1 q=a534", ack1_a, q1_a);
        end
        idle();
        step();
    endtask

    task automatic test_collision();
        logic [1:0]  be_a [2];
        logic [15:0] want [2];
        be_a[0] = 2'b11; want[0] = 16'h1111;
        be_a[1] = 2'b01; want[1] = 16'h2211;
        for (int t = 0; t < 2; t++) begin
            idle();
            ram_cs = 1'b1;   ram_we = 1'b1;   ram_ad = 4'd5;   ram_d = 16'h1111;   ram_be = be_a[t];
            ram_cs_b = 1'b1; ram_we_b = 1'b1; ram_ad_b = 4'd5; ram_d_b = 16'h2222; ram_be_b = 2'b10;
            step();
            idle();
            ram_cs = 1'b1; ram_ad = 4'd5;
            step();
            checks++;
            if ({ack1_a, q1_a} !== {1'b1, want[t]} || ack1_b !== 1'b0) begin
                errors++;
                $display("FAIL collision[%0d]: ack=%b q=%h ack_b=%b, expected ack=1 q=%h ack_b=0",
                         t, ack1_a, q1_a, ack1_b, want[t]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_cross_port();
        idle();
        ram_cs = 1'b1; ram_we = 1'b1; ram_ad = 4'd7; ram_d = 16'hBEEF; ram_be = 2'b11;
        ram_cs_b = 1'b1; ram_ad_b = 4'd7;
        step();
        checks++;
        if ({ack1_b, q1_b} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL cross_old: ack_b=%b q_b=%h, expected ack_b=1 q_b=a5a5", ack1_b, q1_b);
        end
        idle();
        ram_cs_b = 1'b1; ram_ad_b = 4'd7;
        step();
        checks++;
        if ({ack1_b, q1_b} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL cross_new: ack_b=%b q_b=%h, expected ack_b=1 q_b=beef", ack1_b, q1_b);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        for (int a = 0; a < 3; a++) begin
            idle();
            ram_cs_b = 1'b1; ram_we_b = 1'b1; ram_be_b = 2'b11; ram_ad_b = 4'(a);
            ram_d_b = 16'(16'h0100 + a);
            step();
        end
        idle();
        step();
        step();
        for (int s = 1; s <= 5; s++) begin
            idle();
            if (s <= 3) begin
                ram_cs = 1'b1; ram_ad = 4'(s - 1);
            end
            step();
            checks++;
            if (ack2_a !== (s >= 2 && s <= 4)) begin
                errors++;
                $display("FAIL lat2_ack[%0d]: ack=%b, expected %0d", s, ack2_a, s >= 2 && s <= 4);
            end
            if (s >= 2) begin
                want = 16'(16'h0100 + ((s - 2 > 2) ? 2 : s - 2));
                checks++;
                if (q2_a !== want) begin
                    errors++;
                    $display("FAIL lat2_q[%0d]: q=%h, expected %h", s, q2_a, want);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ram_cs   = ($urandom_range(0, 9) < 7);
            ram_cs_b = ($urandom_range(0, 9) < 7);
            ram_we   = 1'($urandom_range(0, 1));
            ram_we_b = 1'($urandom_range(0, 1));
            ram_be   = 2'($urandom_range(0, 3));
            ram_be_b = 2'($urandom_range(0, 3));
            ram_ad   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ram_ad_b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ram_d    = 16'($urandom);
            ram_d_b  = 16'($urandom);
            step();
            checks++;
            if ({q1_a, q1_b, ack1_a, ack1_b, busy1} !== {e1_q[0], e1_q[1], e1_ack[0], e1_ack[1], e_busy}) begin
                errors++;
                $display("FAIL rand_lat1[%0d]: q=%h q_b=%h ack=%b%b busy=%b, expected q=%h q_b=%h ack=%b%b busy=%b",
                         n, q1_a, q1_b, ack1_a, ack1_b, busy1, e1_q[0], e1_q[1], e1_ack[0], e1_ack[1], e_busy);
            end
            checks++;
            if ({q2_a, q2_b, ack2_a, ack2_b, busy2} !== {e2_q[0], e2_q[1], e2_ack[0], e2_ack[1], e_busy}) begin
                errors++;
                $display("FAIL rand_lat2[%0d]: q=%h q_b=%h ack=%b%b busy=%b, expected q=%h q_b=%h ack=%b%b busy=%b",
                         n, q2_a, q2_b, ack2_a, ack2_b, busy2, e2_q[0], e2_q[1], e2_ack[0], e2_ack[1], e_busy);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_reset_mid_clear();
        test_clear_busy();
        test_clear_contents();
        test_byte_write();
        test_collision();
        test_cross_port();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
